// File: rtl/ras.sv
// Return address stack for the fetch stage.
// Pushes PC+4 on a predicted call, pops on a predicted return, and exports a
// ptr/cnt checkpoint with every prediction so the backend can restore it.
// Optional feature macro: RAS_TOP_REPAIR_EN (adds recover_top_i and repairs
// the checkpointed top entry on recovery).
module ras #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_en_i,
  input  logic [1:0]    pred_type_i,
  input  logic [63:0]   pred_pc_i,
  output logic          ret_valid_o,
  output logic [63:0]   ret_target_o,
  output logic [PW-1:0] ptr_o,
  output logic [PW:0]   cnt_o,
  input  logic          recover_en_i,
  input  logic [PW-1:0] recover_ptr_i,
  input  logic [PW:0]   recover_cnt_i,
  input  logic [1:0]    recover_type_i,
  input  logic [63:0]   recover_pc_i
`ifdef RAS_TOP_REPAIR_EN
  ,
  input  logic [63:0]   recover_top_i
`endif
);

  // Prediction type encoding shared with the BTB.
  localparam logic [1:0] TYPE_BRANCH = 2'b00;
  localparam logic [1:0] TYPE_JUMP   = 2'b01;
  localparam logic [1:0] TYPE_CALL   = 2'b10;
  localparam logic [1:0] TYPE_RET    = 2'b11;

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

  logic [61:0]   stack [DEPTH];
  logic [PW-1:0] ptr, ptr_n;
  logic [PW:0]   cnt, cnt_n;

  logic          act;
  logic [1:0]    op_type;
  logic [63:0]   op_pc;
  logic [63:0]   push_addr;
  logic [PW-1:0] base_ptr;
  logic [PW:0]   base_cnt;
  logic          push_en;
  logic [PW-1:0] push_idx;

  // Saturating occupancy increment; overflow wraps the stack circularly.
  function automatic logic [PW:0] cnt_inc(input logic [PW:0] c);
    return (c >= CNT_FULL) ? CNT_FULL : c + CNT_ONE;
  endfunction

  // Combinational outputs straight from current state (zero-latency prediction).
  always_comb begin
    ret_valid_o  = (cnt != '0);
    ret_target_o = ret_valid_o ? {stack[ptr], 2'b00} : 64'd0;
    ptr_o        = ptr;
    cnt_o        = cnt;
  end

  // Select the operation for this cycle: recovery wins over prediction.
  always_comb begin
    act      = 1'b0;
    op_type  = TYPE_BRANCH;
    op_pc    = 64'd0;
    base_ptr = ptr;
    base_cnt = cnt;
    if (recover_en_i) begin
      act      = 1'b1;
      op_type  = recover_type_i;
      op_pc    = recover_pc_i;
      base_ptr = recover_ptr_i;
      base_cnt = recover_cnt_i;
    end else if (pred_en_i) begin
      act      = 1'b1;
      op_type  = pred_type_i;
      op_pc    = pred_pc_i;
    end
  end

  assign push_addr = op_pc + 64'd4;
  assign push_idx  = base_ptr + PTR_ONE;

  // Next ptr/cnt from the base plus the selected push/pop/no-op.
  always_comb begin
    ptr_n   = ptr;
    cnt_n   = cnt;
    push_en = 1'b0;
    if (act) begin
      ptr_n = base_ptr;
      cnt_n = base_cnt;
      case (op_type)
        TYPE_CALL: begin
          push_en = 1'b1;
          ptr_n   = push_idx;
          cnt_n   = cnt_inc(base_cnt);
        end
        TYPE_RET: begin
          if (base_cnt != '0) begin
            ptr_n = base_ptr - PTR_ONE;
            cnt_n = base_cnt - CNT_ONE;
          end
        end
        TYPE_BRANCH, TYPE_JUMP: ;
        default: ;
      endcase
    end
  end

  // Control state register; reset discards any same-cycle operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end

  // Stack storage (not reset); top repair is written before the resolved push.
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef RAS_TOP_REPAIR_EN
      if (recover_en_i && (recover_cnt_i != '0))
        stack[recover_ptr_i] <= recover_top_i[63:2];
`endif
      if (push_en)
        stack[push_idx] <= push_addr[63:2];
    end
  end

`ifdef RAS_TOP_REPAIR_EN
  logic unused_top_bits;
  assign unused_top_bits = ^recover_top_i[1:0];
`endif

endmodule
